rv32i_csr_file: RTL



---
 rtl/rv32i_csr_file.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rv32i_csr_file.sv
// Machine-mode CSR file: trap state, mtvec/mscratch, 64-bit mcycle/minstret with RO shadows.
// Counters are built only when RV32I_CSR_COUNTERS_EN is defined.
module rv32i_csr_file #(
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [11:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instret_inc,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out,
  output logic        mstatus_mie
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
  localparam logic [11:0] A_MCYC_LO  = 12'hB00;
  localparam logic [11:0] A_MCYC_HI  = 12'hB80;
  localparam logic [11:0] A_MINS_LO  = 12'hB02;
  localparam logic [11:0] A_MINS_HI  = 12'hB82;
  localparam logic [11:0] A_CYC_LO   = 12'hC00;
  localparam logic [11:0] A_CYC_HI   = 12'hC80;
  localparam logic [11:0] A_INS_LO   = 12'hC02;
  localparam logic [11:0] A_INS_HI   = 12'hC82;

  logic        mst_mie, mst_mpie;
  logic [31:0] mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r;

  // Read-back image of mstatus: MPP hard-wired to M-mode (bits 12:11).
  function automatic logic [31:0] mstatus_view(input logic mpie, input logic mie);
    return {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
  endfunction

  function automatic logic is_writable(input logic [11:0] addr);
    logic w;
    w = 1'b0;
    case (addr)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE: w = 1'b1;
`ifdef RV32I_CSR_COUNTERS_EN
      A_MCYC_LO, A_MCYC_HI, A_MINS_LO, A_MINS_HI: w = 1'b1;
`endif
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  // Value a write would leave visible at addr (used for the bypass path).
  function automatic logic [31:0] write_view(input logic [11:0] addr, input logic [31:0] wdata);
    logic [31:0] v;
    v = wdata;
    case (addr)
      A_MSTATUS:      v = mstatus_view(wdata[7], wdata[3]);
      A_MTVEC, A_MEPC: v = {wdata[31:2], 2'b00};
      default:        v = wdata;
    endcase
    return v;
  endfunction

`ifdef RV32I_CSR_COUNTERS_EN
  logic [63:0] mcycle_r, minstret_r;

  // A write to either half replaces the increment for the whole counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else begin
      if (csr_we && csr_waddr == A_MCYC_LO)      mcycle_r[31:0]  <= csr_wdata;
      else if (csr_we && csr_waddr == A_MCYC_HI) mcycle_r[63:32] <= csr_wdata;
      else                                       mcycle_r        <= mcycle_r + 64'd1;
      if (csr_we && csr_waddr == A_MINS_LO)      minstret_r[31:0]  <= csr_wdata;
      else if (csr_we && csr_waddr == A_MINS_HI) minstret_r[63:32] <= csr_wdata;
      else                                       minstret_r        <= minstret_r + {63'd0, instret_inc};
    end
  end
`else
  logic unused_instret;
  assign unused_instret = instret_inc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_r      <= 32'd0;
      mtvec_r    <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_r <= 32'd0;
      mepc_r     <= 32'd0;
      mcause_r   <= 32'd0;
    end else begin
      if (trap_valid) begin
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (mret) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (csr_we && csr_waddr == A_MSTATUS) begin
        mst_mie  <= csr_wdata[3];
        mst_mpie <= csr_wdata[7];
      end
      if (trap_valid)                           mepc_r <= {trap_pc[31:2], 2'b00};
      else if (csr_we && csr_waddr == A_MEPC)   mepc_r <= {csr_wdata[31:2], 2'b00};
      if (trap_valid)                           mcause_r <= trap_cause;
      else if (csr_we && csr_waddr == A_MCAUSE) mcause_r <= csr_wdata;
      if (csr_we && csr_waddr == A_MIE)      mie_r      <= csr_wdata;
      if (csr_we && csr_waddr == A_MTVEC)    mtvec_r    <= {csr_wdata[31:2], 2'b00};
      if (csr_we && csr_waddr == A_MSCRATCH) mscratch_r <= csr_wdata;
    end
  end

  always_comb begin
    csr_rdata   = 32'd0;
    csr_illegal = 1'b0;
    case (csr_raddr)
      A_MSTATUS:  csr_rdata = mstatus_view(mst_mpie, mst_mie);
      A_MISA:     csr_rdata = MISA_VALUE;
      A_MIE:      csr_rdata = mie_r;
      A_MTVEC:    csr_rdata = mtvec_r;
      A_MSCRATCH: csr_rdata = mscratch_r;
      A_MEPC:     csr_rdata = mepc_r;
      A_MCAUSE:   csr_rdata = mcause_r;
      A_MHARTID:  csr_rdata = MHARTID;
`ifdef RV32I_CSR_COUNTERS_EN
      A_MCYC_LO, A_CYC_LO: csr_rdata = mcycle_r[31:0];
      A_MCYC_HI, A_CYC_HI: csr_rdata = mcycle_r[63:32];
      A_MINS_LO, A_INS_LO: csr_rdata = minstret_r[31:0];
      A_MINS_HI, A_INS_HI: csr_rdata = minstret_r[63:32];
`endif
      default:    csr_illegal = 1'b1;
    endcase
    if (csr_we && csr_waddr == csr_raddr && is_writable(csr_raddr))
      csr_rdata = write_view(csr_raddr, csr_wdata);
  end

  assign trap_vector = {mtvec_r[31:2], 2'b00};
  assign mepc_out    = mepc_r;
  assign mstatus_mie = mst_mie;

endmodule
